config_frame_loader: RTL and testbench



---
 rtl/config_frame_loader.sv | 168 ++++++++++++++++
 tb/tb_config_frame_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/config_frame_loader.sv
// Assembles configuration frames (sync, header, NUM_ROWS data words) from the serial receiver word stream.
// Optional build macro FRAME_CHECK_EN adds a trailing XOR checksum word per frame (CHECK state).
module config_frame_loader #(
    parameter int          NUM_ROWS       = 16,
    parameter int          NUM_COLUMNS    = 16,
    parameter int          FRAMES_PER_COL = 20,
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
    parameter logic [31:0] DESYNC_WORD    = 32'hFAB0_FAB0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              write_data,
    input  logic                     write_strobe,
    input  logic                     write_active,
    output logic [NUM_ROWS*32-1:0]   frame_data,
    output logic [NUM_COLUMNS-1:0]   frame_col_sel,
    output logic [7:0]               frame_index,
    output logic                     frame_strobe,
    output logic                     busy,
    output logic                     error
);

    localparam int                      FW      = NUM_ROWS * 32;
    localparam int                      CW      = $clog2(NUM_ROWS + 1);
    localparam logic [CW-1:0]           LAST    = CW'(NUM_ROWS - 1);
    localparam logic [NUM_COLUMNS-1:0]  COL_ONE = NUM_COLUMNS'(1);

`ifdef FRAME_CHECK_EN
    typedef enum logic [1:0] {IDLE, HEADER, DATA, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
`endif

    state_t            state, next_state;
    logic [CW-1:0]     word_cnt;
    logic [FW-1:0]     shreg;
    logic [FW-1:0]     shifted;
    logic [FW-1:0]     emit_data;
    logic [7:0]        col_q;
    logic [7:0]        idx_q;
    logic              hdr_ok;
    logic              shift_en;
    logic              hdr_load;
    logic              err_clr;
    logic              last_word;
    logic              emit;
    logic              err_set;
`ifdef FRAME_CHECK_EN
    logic              chk_word;
    logic [31:0]       xor_acc;
`endif

    assign shifted = {shreg[FW-33:0], write_data};
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Abort on a dropped active flag outranks any word offered in the same cycle.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        hdr_load   = 1'b0;
        err_clr    = 1'b0;
        last_word  = 1'b0;
`ifdef FRAME_CHECK_EN
        chk_word   = 1'b0;
`endif
        if (state != IDLE && !write_active) begin
            next_state = IDLE;
        end else if (write_strobe) begin
            case (state)
                IDLE: begin
                    if (write_data == SYNC_WORD) begin
                        next_state = HEADER;
                        err_clr    = 1'b1;
                    end
                end
                HEADER: begin
                    if (write_data == SYNC_WORD) begin
                        err_clr = 1'b1;
                    end else if (write_data == DESYNC_WORD) begin
                        next_state = IDLE;
                    end else begin
                        hdr_load   = 1'b1;
                        next_state = DATA;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (word_cnt == LAST) begin
                        last_word  = 1'b1;
`ifdef FRAME_CHECK_EN
                        next_state = CHECK;
`else
                        next_state = HEADER;
`endif
                    end
                end
`ifdef FRAME_CHECK_EN
                CHECK: begin
                    chk_word   = 1'b1;
                    next_state = HEADER;
                end
`endif
                default: next_state = IDLE;
            endcase
        end
    end

`ifdef FRAME_CHECK_EN
    assign emit      = chk_word && hdr_ok && (write_data == xor_acc);
    assign err_set   = chk_word && !(hdr_ok && (write_data == xor_acc));
    assign emit_data = shreg;
`else
    assign emit      = last_word && hdr_ok;
    assign err_set   = last_word && !hdr_ok;
    assign emit_data = shifted;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_cnt      <= '0;
            shreg         <= '0;
            col_q         <= '0;
            idx_q         <= '0;
            hdr_ok        <= 1'b0;
            frame_data    <= '0;
            frame_col_sel <= '0;
            frame_index   <= '0;
            frame_strobe  <= 1'b0;
            error         <= 1'b0;
        end else begin
            frame_strobe  <= emit;
            frame_col_sel <= emit ? (COL_ONE << col_q) : '0;
            if (emit) begin
                frame_data  <= emit_data;
                frame_index <= idx_q;
            end

            if (err_clr)      error <= 1'b0;
            else if (err_set) error <= 1'b1;

            if (hdr_load) begin
                col_q  <= write_data[31:24];
                idx_q  <= write_data[7:0];
                hdr_ok <= (int'(write_data[31:24]) < NUM_COLUMNS) &&
                          (int'(write_data[7:0]) < FRAMES_PER_COL);
            end
            if (shift_en) shreg <= shifted;

            // Counter only lives inside DATA; any exit (completion or abort) parks it at 0.
            if (next_state == DATA) word_cnt <= shift_en ? word_cnt + 1'b1 : word_cnt;
            else                    word_cnt <= '0;
        end
    end

`ifdef FRAME_CHECK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       xor_acc <= '0;
        else if (hdr_load) xor_acc <= write_data;
        else if (shift_en) xor_acc <= xor_acc ^ write_data;
    end
`endif

endmodule

// File: tb/tb_config_frame_loader.sv
// Bench for config_frame_loader (NUM_ROWS=2, NUM_COLUMNS=4, FRAMES_PER_COL=3); table vectors plus corner sequences.
`timescale 1ns/1ps
module tb_config_frame_loader;

    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] write_data = '0;
    logic        write_strobe = 1'b0;
    logic        write_active = 1'b1;
    logic [63:0] frame_data;
    logic [3:0]  frame_col_sel;
    logic [7:0]  frame_index;
    logic        frame_strobe;
    logic        busy;
    logic        error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        ok;
        logic [3:0]  col;
        logic [7:0]  idx;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  col;
        logic [7:0]  idx;
        int          cyc;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    exp_t mon_e;

    config_frame_loader #(
        .NUM_ROWS(2),
        .NUM_COLUMNS(4),
        .FRAMES_PER_COL(3)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .write_data(write_data),
        .write_strobe(write_strobe),
        .write_active(write_active),
        .frame_data(frame_data),
        .frame_col_sel(frame_col_sel),
        .frame_index(frame_index),
        .frame_strobe(frame_strobe),
        .busy(busy),
        .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Emitted frames are popped and compared here, including the cycle they arrive in.
    always @(negedge clk) begin
        if (resetn) begin
            if (frame_strobe) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("frame_data", frame_data, mon_e.data);
                    chk("frame_col_sel", 64'(frame_col_sel), 64'(mon_e.col));
                    chk("frame_index", 64'(frame_index), 64'(mon_e.idx));
                end
            end else begin
                chk("col_sel_quiet", 64'(frame_col_sel), 64'd0);
            end
        end
    end

    task automatic word(input logic [31:0] w);
        write_data   = w;
        write_strobe = 1'b1;
        @(posedge clk);
        #1;
        write_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [63:0] d, input logic [3:0] c, input logic [7:0] i);
        exp_t e;
        e.data = d;
        e.col  = c;
        e.idx  = i;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] d0, input logic [31:0] d1,
                              input logic ok, input logic [3:0] c, input logic [7:0] i,
                              input logic corrupt);
        word(hdr);
        word(d0);
`ifdef FRAME_CHECK_EN
        word(d1);
        if (ok && !corrupt) expect_frame({d0, d1}, c, i);
        word(hdr ^ d0 ^ d1 ^ {31'd0, corrupt});
`else
        if (ok && !corrupt) expect_frame({d0, d1}, c, i);
        word(d1);
`endif
    endtask

    initial begin
        vecs[0] = '{32'h0200_0001, 32'h1111_1111, 32'h2222_2222, 1'b1, 4'b0100, 8'd1};
        vecs[1] = '{32'h0000_0000, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 4'b0001, 8'd0};
        vecs[2] = '{32'h03FF_FF02, 32'hFAB0_FAB0, 32'hFAB0_FAB1, 1'b1, 4'b1000, 8'd2};
        vecs[3] = '{32'h0500_0000, 32'h0000_0001, 32'h0000_0002, 1'b0, 4'b0000, 8'd0};
        vecs[4] = '{32'h0100_0003, 32'h0000_0003, 32'h0000_0004, 1'b0, 4'b0000, 8'd0};
        vecs[5] = '{32'h0104_0502, 32'h0BAD_F00D, 32'h1234_5678, 1'b1, 4'b0010, 8'd2};

        // Reset state
        #12;
        chk("rst_frame_data", frame_data, 64'd0);
        chk("rst_col_sel", 64'(frame_col_sel), 64'd0);
        chk("rst_index", 64'(frame_index), 64'd0);
        chk("rst_strobe", 64'(frame_strobe), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);

        // Words before sync are ignored; sync/desync toggle busy
        word(32'h0200_0001);
        word(32'h1111_1111);
        word(DESYNC);
        chk("pre_sync_busy", 64'(busy), 64'd0);
        word(SYNC);
        chk("sync_busy", 64'(busy), 64'd1);
        word(DESYNC);
        chk("desync_busy", 64'(busy), 64'd0);
        idle(2);

        // Table-driven frames
        for (int k = 0; k < 6; k++) begin
            word(SYNC);
            chk("sync_clears_error", 64'(error), 64'd0);
            send_frame(vecs[k].hdr, vecs[k].d0, vecs[k].d1, vecs[k].ok, vecs[k].col, vecs[k].idx, 1'b0);
            chk("frame_end_error", 64'(error), 64'(!vecs[k].ok));
            chk("frame_end_busy", 64'(busy), 64'd1);
            idle(1);
        end

        // Abort mid-DATA, with a same-cycle strobe that must be dropped
        word(SYNC);
        word(32'h0100_0001);
        word(32'hDEAD_BEEF);
        write_active = 1'b0;
        word(32'h1234_5678);
        chk("abort_busy", 64'(busy), 64'd0);
        write_active = 1'b1;
        idle(3);
        word(SYNC);
        send_frame(32'h0100_0001, 32'hCAFE_0001, 32'h0BAD_0002, 1'b1, 4'b0010, 8'd1, 1'b0);
        idle(2);

        // Back-to-back frames, sync word carried as data
        word(SYNC);
        send_frame(32'h0300_0000, SYNC, 32'h0000_0001, 1'b1, 4'b1000, 8'd0, 1'b0);
        send_frame(32'h0000_0002, 32'h7777_0000, 32'h0000_8888, 1'b1, 4'b0001, 8'd2, 1'b0);
        idle(3);
        chk("frame_data_hold", frame_data, 64'h7777_0000_0000_8888);
        chk("frame_index_hold", 64'(frame_index), 64'd2);

`ifdef FRAME_CHECK_EN
        // Checksum off by one bit
        word(SYNC);
        send_frame(32'h0200_0000, 32'h0000_00F0, 32'h0F00_0000, 1'b1, 4'b0100, 8'd0, 1'b1);
        chk("bad_checksum_error", 64'(error), 64'd1);
        idle(2);
        word(SYNC);
        chk("resync_clears_error", 64'(error), 64'd0);
        send_frame(32'h0200_0000, 32'h0000_00F0, 32'h0F00_0000, 1'b1, 4'b0100, 8'd0, 1'b0);
        idle(2);
`endif

        // Asynchronous reset in the middle of DATA with error set
        word(SYNC);
        send_frame(32'h0500_0000, 32'h1, 32'h2, 1'b0, 4'b0000, 8'd0, 1'b0);
        chk("pre_reset_error", 64'(error), 64'd1);
        word(32'h0100_0001);
        word(32'h5555_5555);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_frame_data", frame_data, 64'd0);
        chk("async_rst_index", 64'(frame_index), 64'd0);
        chk("async_rst_col_sel", 64'(frame_col_sel), 64'd0);
        chk("async_rst_strobe", 64'(frame_strobe), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_error", 64'(error), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        word(32'h6666_6666);
        idle(3);
        chk("post_reset_busy", 64'(busy), 64'd0);

        idle(4);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
